uart_cmd_rx: RTL and testbench

//   Oversampling UART receiver with command assembly. Takes the serial rx line and collects
//   CMD_BYTES consecutive characters into one {id, payload} command, which it presents on a

---
 rtl/uart_cmd_rx.sv | 219 +++++++++++++++++++++
 tb/tb_uart_cmd_rx.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_rx.sv
// Oversampling UART receiver that assembles CMD_BYTES characters into one {id, payload}
// command and presents it on a valid/ready interface, with frame/parity/overrun/timeout pulses.
module uart_cmd_rx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CMD_BYTES    = 5,
    parameter int unsigned ID_W         = 8,
    parameter int unsigned PAYLOAD_W    = 32,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned GAP_TIMEOUT  = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [ID_W-1:0]      cmd_id,
    output logic [PAYLOAD_W-1:0] cmd_payload,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 timeout,
    output logic                 busy
);

    localparam int unsigned CMD_W = ID_W + PAYLOAD_W;
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
    localparam int unsigned IDX_W = $clog2(CMD_BYTES + 1);
    localparam int unsigned GAP_W = $clog2(GAP_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] HalfLast = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BitLast  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DataLast = BIT_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IdxLast  = IDX_W'(CMD_BYTES - 1);
    localparam logic [GAP_W-1:0] GapLast  = GAP_W'(GAP_TIMEOUT - 1);
    localparam logic             ParOdd   = (PARITY_ODD != 0);
    localparam logic             ParEn    = (PARITY_EN != 0);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e                 state_q, state_d;
    logic                   rx_meta_q, rs_q, rs_prev_q;
    logic [CNT_W-1:0]       clk_cnt_q, clk_cnt_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   char_q, char_d;
    logic                   bad_q, bad_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [CMD_W-1:0]       buf_q, buf_d;
    logic                   valid_q, valid_d;
    logic [ID_W-1:0]        id_q, id_d;
    logic [PAYLOAD_W-1:0]   pay_q, pay_d;
    logic                   frame_err_q, frame_err_d, parity_err_q, parity_err_d;
    logic                   overrun_q, overrun_d, timeout_q, timeout_d;
    logic                   done;

    always_comb begin
        state_d      = state_q;
        clk_cnt_d    = clk_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        char_d       = char_q;
        bad_d        = bad_q;
        idx_d        = idx_q;
        gap_d        = gap_q;
        buf_d        = buf_q;
        valid_d      = valid_q;
        id_d         = id_q;
        pay_d        = pay_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        overrun_d    = 1'b0;
        timeout_d    = 1'b0;
        done         = 1'b0;

        unique case (state_q)
            StIdle: begin
                clk_cnt_d = '0;
                if (rs_prev_q && !rs_q) begin
                    state_d = StStart;
                    gap_d   = '0;
                end else if (idx_q != '0) begin
                    if (gap_q == GapLast) begin
                        timeout_d = 1'b1;
                        idx_d     = '0;
                        gap_d     = '0;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end else begin
                    gap_d = '0;
                end
            end
            StStart: begin
                if (clk_cnt_q == HalfLast) begin
                    clk_cnt_d = '0;
                    if (rs_q) begin
                        state_d = StIdle;
                    end else begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                        bad_d     = 1'b0;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            StData: begin
                if (clk_cnt_q == BitLast) begin
                    clk_cnt_d = '0;
                    char_d    = {rs_q, char_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == DataLast) state_d = ParEn ? StParity : StStop;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            StParity: begin
                if (clk_cnt_q == BitLast) begin
                    clk_cnt_d = '0;
                    state_d   = StStop;
                    if (rs_q != ((^char_q) ^ ParOdd)) begin
                        parity_err_d = 1'b1;
                        bad_d        = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            StStop: begin
                if (clk_cnt_q == BitLast) begin
                    clk_cnt_d = '0;
                    state_d   = StIdle;
                    if (!rs_q) begin
                        frame_err_d = 1'b1;
                        idx_d       = '0;
                    end else if (bad_q) begin
                        idx_d = '0;
                    end else begin
                        // Characters shift in from the top so the first lands in the low bits.
                        buf_d = {char_q, buf_q[CMD_W-1:DATA_BITS]};
                        if (idx_q == IdxLast) begin
                            idx_d = '0;
                            done  = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (valid_q && cmd_ready) valid_d = 1'b0;
        if (done) begin
            if (valid_q && !cmd_ready) begin
                overrun_d = 1'b1;
            end else begin
                valid_d       = 1'b1;
                {id_d, pay_d} = buf_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q    <= 1'b1;
            rs_q         <= 1'b1;
            rs_prev_q    <= 1'b1;
            state_q      <= StIdle;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            char_q       <= '0;
            bad_q        <= 1'b0;
            idx_q        <= '0;
            gap_q        <= '0;
            buf_q        <= '0;
            valid_q      <= 1'b0;
            id_q         <= '0;
            pay_q        <= '0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            rx_meta_q    <= rx;
            rs_q         <= rx_meta_q;
            rs_prev_q    <= rs_q;
            state_q      <= state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            char_q       <= char_d;
            bad_q        <= bad_d;
            idx_q        <= idx_d;
            gap_q        <= gap_d;
            buf_q        <= buf_d;
            valid_q      <= valid_d;
            id_q         <= id_d;
            pay_q        <= pay_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
        end
    end

    assign cmd_valid   = valid_q;
    assign cmd_id      = id_q;
    assign cmd_payload = pay_q;
    assign frame_err   = frame_err_q;
    assign parity_err  = parity_err_q;
    assign overrun     = overrun_q;
    assign timeout     = timeout_q;
    assign busy        = (state_q != StIdle) || (idx_q != '0);

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Scoreboard bench for uart_cmd_rx: a default-parameter instance and an odd-parity instance.
module tb_uart_cmd_rx;

    logic        clk = 1'b0;
    logic        rst_n, rst_p_n;
    logic        rx, rx_p;
    logic        cmd_ready, cmd_ready_p;
    logic        cmd_valid, cmd_valid_p;
    logic [7:0]  cmd_id, cmd_id_p;
    logic [31:0] cmd_payload, cmd_payload_p;
    logic        frame_err, parity_err, overrun, timeout, busy;
    logic        frame_err_p, parity_err_p, overrun_p, timeout_p, busy_p;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0, to_cnt = 0;
    int fe_p_cnt = 0, pe_p_cnt = 0, ov_p_cnt = 0, to_p_cnt = 0;
    logic [39:0] exp_q[$];
    logic [39:0] exp_p_q[$];

    always #5 clk = ~clk;

    uart_cmd_rx dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_id(cmd_id), .cmd_payload(cmd_payload), .frame_err(frame_err),
        .parity_err(parity_err), .overrun(overrun), .timeout(timeout), .busy(busy)
    );

    uart_cmd_rx #(.PARITY_EN(1), .PARITY_ODD(1)) dut_p (
        .clk(clk), .rst_n(rst_p_n), .rx(rx_p), .cmd_valid(cmd_valid_p),
        .cmd_ready(cmd_ready_p), .cmd_id(cmd_id_p), .cmd_payload(cmd_payload_p),
        .frame_err(frame_err_p), .parity_err(parity_err_p), .overrun(overrun_p),
        .timeout(timeout_p), .busy(busy_p)
    );

    // Handshakes are judged just after the falling edge, once the bench has driven cmd_ready.
    always @(negedge clk) begin
        logic [39:0] e;
        #1;
        if (cmd_valid && cmd_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_cmd got %h_%h, none expected", cmd_id, cmd_payload);
            end else begin
                e = exp_q.pop_front();
                if ({cmd_id, cmd_payload} !== e) begin
                    errors++;
                    $display("FAIL cmd got %h_%h expected %h_%h", cmd_id, cmd_payload,
                             e[39:32], e[31:0]);
                end
            end
        end
        if (cmd_valid_p && cmd_ready_p) begin
            checks++;
            if (exp_p_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_cmd_p got %h_%h", cmd_id_p, cmd_payload_p);
            end else begin
                e = exp_p_q.pop_front();
                if ({cmd_id_p, cmd_payload_p} !== e) begin
                    errors++;
                    $display("FAIL cmd_p got %h_%h expected %h_%h", cmd_id_p, cmd_payload_p,
                             e[39:32], e[31:0]);
                end
            end
        end
        fe_cnt += int'(frame_err);   pe_cnt += int'(parity_err);
        ov_cnt += int'(overrun);     to_cnt += int'(timeout);
        fe_p_cnt += int'(frame_err_p); pe_p_cnt += int'(parity_err_p);
        ov_p_cnt += int'(overrun_p);   to_p_cnt += int'(timeout_p);
    end

    task automatic set_rx(input int sel, input logic v);
        if (sel == 0) rx = v;
        else rx_p = v;
    endtask

    task automatic bit_time(input int sel, input logic v);
        set_rx(sel, v);
        repeat (16) @(negedge clk);
    endtask

    // sel 1 targets the odd-parity instance and adds a parity bit (inverted when bad_par).
    task automatic send_char(input int sel, input logic [7:0] b, input logic stop_bit,
                             input logic bad_par);
        bit_time(sel, 1'b0);
        for (int i = 0; i < 8; i++) bit_time(sel, b[i]);
        if (sel == 1) bit_time(sel, (~^b) ^ bad_par);
        bit_time(sel, stop_bit);
        set_rx(sel, 1'b1);
    endtask

    task automatic send_cmd(input int sel, input logic [7:0] id, input logic [31:0] pay,
                            input logic expect_it);
        logic [39:0] c;
        c = {id, pay};
        if (expect_it) begin
            if (sel == 0) exp_q.push_back(c);
            else exp_p_q.push_back(c);
        end
        for (int k = 0; k < 5; k++) send_char(sel, c[k*8 +: 8], 1'b1, 1'b0);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_p_q.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || exp_p_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain pending %0d/%0d required 0/0", name, exp_q.size(),
                     exp_p_q.size());
        end
    endtask

    task automatic test_reset();
        rx = 1'b1; rx_p = 1'b1; cmd_ready = 1'b1; cmd_ready_p = 1'b1;
        rst_n = 1'b0; rst_p_n = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ({cmd_valid, cmd_id, cmd_payload, frame_err, parity_err, overrun, timeout, busy}
            !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h required 0", {cmd_valid, cmd_id, cmd_payload,
                     frame_err, parity_err, overrun, timeout, busy});
        end
        rst_n = 1'b1; rst_p_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if ({cmd_valid, busy, cmd_valid_p, busy_p} !== 4'b0) begin
            errors++;
            $display("FAIL post_reset valid/busy got %b%b%b%b required 0000", cmd_valid, busy,
                     cmd_valid_p, busy_p);
        end
    endtask

    task automatic test_single();
        send_cmd(0, 8'h03, 32'h0000_023C, 1'b1);
        wait_drain("single");
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_valid_drop got %b required 0", cmd_valid);
        end
    endtask

    task automatic test_back_to_back();
        int fe0, pe0, ov0, to0;
        fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt; to0 = to_cnt;
        for (int p = 572; p <= 616; p++) send_cmd(0, 8'h03, 32'(p), 1'b1);
        wait_drain("b2b");
        checks++;
        if ({fe_cnt - fe0, pe_cnt - pe0, ov_cnt - ov0, to_cnt - to0} !== 128'b0) begin
            errors++;
            $display("FAIL b2b_pulses got fe%0d pe%0d ov%0d to%0d required 0", fe_cnt - fe0,
                     pe_cnt - pe0, ov_cnt - ov0, to_cnt - to0);
        end
    endtask

    task automatic test_overrun();
        int ov0;
        ov0 = ov_cnt;
        cmd_ready = 1'b0;
        send_cmd(0, 8'hA5, 32'hDEAD_BEEF, 1'b1);
        send_cmd(0, 8'h5A, 32'h1234_5678, 1'b0);
        repeat (10) @(negedge clk);
        checks++;
        if (ov_cnt - ov0 != 1) begin
            errors++;
            $display("FAIL overrun_count got %0d required 1", ov_cnt - ov0);
        end
        checks++;
        if ({cmd_valid, cmd_id, cmd_payload} !== {1'b1, 8'hA5, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL overrun_held got %b %h_%h required 1 a5_deadbeef", cmd_valid,
                     cmd_id, cmd_payload);
        end
        cmd_ready = 1'b1;
        wait_drain("overrun");
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL overrun_valid_drop got %b required 0", cmd_valid);
        end
    endtask

    task automatic test_glitch_frame();
        int fe0, pe0, ov0, to0;
        fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt; to0 = to_cnt;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if ({busy, cmd_valid} !== 2'b00 || (fe_cnt + pe_cnt + ov_cnt + to_cnt) !=
            (fe0 + pe0 + ov0 + to0)) begin
            errors++;
            $display("FAIL glitch got busy %b valid %b pulses %0d required 0 0 0", busy,
                     cmd_valid, (fe_cnt + pe_cnt + ov_cnt + to_cnt) - (fe0 + pe0 + ov0 + to0));
        end
        send_char(0, 8'h55, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        checks++;
        if (fe_cnt - fe0 != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL frame_err got count %0d busy %b required 1 0", fe_cnt - fe0, busy);
        end
        send_cmd(0, 8'h7E, 32'hCAFE_0042, 1'b1);
        wait_drain("after_frame");
    endtask

    task automatic test_timeout();
        int to0;
        to0 = to_cnt;
        send_char(0, 8'h11, 1'b1, 1'b0);
        send_char(0, 8'h22, 1'b1, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL partial_busy got %b required 1", busy);
        end
        repeat (1100) @(negedge clk);
        checks++;
        if (to_cnt - to0 != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout got count %0d busy %b required 1 0", to_cnt - to0, busy);
        end
        send_cmd(0, 8'h03, 32'h0BAD_F00D, 1'b1);
        wait_drain("after_timeout");
    endtask

    task automatic test_parity_reset();
        int pe0;
        pe0 = pe_p_cnt;
        send_char(1, 8'h3C, 1'b1, 1'b0);
        send_char(1, 8'h81, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        checks++;
        if (pe_p_cnt - pe0 != 1 || busy_p !== 1'b0 || cmd_valid_p !== 1'b0) begin
            errors++;
            $display("FAIL parity_err got count %0d busy %b valid %b required 1 0 0",
                     pe_p_cnt - pe0, busy_p, cmd_valid_p);
        end
        // One good character, then a reset part-way through the next one.
        send_char(1, 8'h99, 1'b1, 1'b0);
        bit_time(1, 1'b0);
        bit_time(1, 1'b1);
        bit_time(1, 1'b0);
        rst_p_n = 1'b0;
        rx_p = 1'b1;
        repeat (3) @(negedge clk);
        rst_p_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if ({busy_p, cmd_valid_p} !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset got busy %b valid %b required 0 0", busy_p, cmd_valid_p);
        end
        send_cmd(1, 8'hC3, 32'h8765_4321, 1'b1);
        wait_drain("parity_after_reset");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_glitch_frame();
        test_timeout();
        test_parity_reset();
        checks++;
        if (pe_cnt != 0 || ov_p_cnt != 0 || fe_p_cnt != 0 || to_p_cnt != 0) begin
            errors++;
            $display("FAIL stray_pulses got pe%0d ovp%0d fep%0d top%0d required 0", pe_cnt,
                     ov_p_cnt, fe_p_cnt, to_p_cnt);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
